aes_enc_ctrl: RTL and testbench

AES_ENC_CTRL -- requirements
Module: aes_enc_ctrl

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_key_step.sv | 21 ++
 rtl/aes_enc_ctrl.sv | 84 ++++++++
 tb/tb_aes_enc_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 controller types, constants and byte-level helpers.
//   NR      : number of rounds (10, AES-128 only)
//   block_t : 128-bit block, MSB-first bytes, column-major state
//   state_e : controller FSM states
//   RCON    : round constants for rounds 1..10
//   sbox()  : forward S-box lookup
//   rcon_at : round constant for a 1-based round number (0 outside 1..NR)
package aes_pkg;
    localparam int NR = 10;
    typedef logic [127:0] block_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    // Byte 0x00 sits in the top eight bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction
    function automatic logic [7:0] rcon_at(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'(NR)) ? RCON[r - 4'd1] : 8'h00;
    endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: combinational AES-128 key expansion step (one round key to the next).
//   rkey_i : current round key
//   rcon_i : round constant applied to this step
//   key_o  : next round key
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rkey_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    assign {w0, w1, w2, w3} = rkey_i;
    // SubWord(RotWord(w3)) with rcon folded into the leading byte.
    assign t  = {sbox(w3[23:16]) ^ rcon_i, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_o = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl: AES-128 encryption controller sequencing an external round datapath.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : plaintext/key input handshake
//   plaintext, key        : input block and cipher key
//   out_valid/out_ready   : ciphertext output handshake
//   ciphertext            : result block, held until taken
//   rd_state/rd_key       : state and round key driven to the round datapath
//   rd_last               : final round, datapath skips MixColumns
//   rd_result             : combinational round result from the datapath
//   busy                  : block in flight (ROUND or DONE)
//   blk_count             : completed-block counter, present only with AES_CTRL_BLK_CNT_EN
module aes_enc_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] rd_state,
    output logic [127:0] rd_key,
    output logic         rd_last,
    input  logic [127:0] rd_result,
    output logic         busy
`ifdef AES_CTRL_BLK_CNT_EN
   ,output logic [31:0]  blk_count
`endif
);
    import aes_pkg::*;
    state_e     fsm_q;
    block_t     state_q, rkey_q, next_key;
    logic [3:0] round_q;
    // The key for round n is derived on the fly from the key of round n-1.
    aes_key_step u_key_step (
        .rkey_i (rkey_q),
        .rcon_i (rcon_at(round_q)),
        .key_o  (next_key)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            rkey_q  <= '0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
                    state_q <= plaintext ^ key;
                    rkey_q  <= key;
                    round_q <= 4'd1;
                    fsm_q   <= ROUND;
                end
                ROUND: begin
                    state_q <= rd_result;
                    rkey_q  <= next_key;
                    // The counter stops at NR so it never exceeds the round count.
                    if (round_q == 4'(NR)) fsm_q <= DONE;
                    else round_q <= round_q + 4'd1;
                end
                DONE: if (out_ready) fsm_q <= IDLE;
                default: fsm_q <= IDLE;
            endcase
        end
    end
`ifdef AES_CTRL_BLK_CNT_EN
    logic [31:0] blk_count_q;
    always_ff @(posedge clk) begin
        if (rst) blk_count_q <= '0;
        else if (fsm_q == DONE && out_ready) blk_count_q <= blk_count_q + 32'd1;
    end
    assign blk_count = blk_count_q;
`endif
    assign in_ready   = fsm_q == IDLE;
    assign out_valid  = fsm_q == DONE;
    assign busy       = fsm_q != IDLE;
    assign rd_last    = fsm_q == ROUND && round_q == 4'(NR);
    assign ciphertext = state_q;
    assign rd_state   = state_q;
    assign rd_key     = next_key;
endmodule

// File: tb/tb_aes_enc_ctrl.sv
// tb_aes_enc_ctrl: directed FIPS-197 vectors against aes_enc_ctrl with a behavioural round datapath.
module tb_aes_enc_ctrl;
    import aes_pkg::sbox;
    logic         clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic         in_ready, out_valid, rd_last, busy;
    logic [127:0] plaintext = '0, key = '0, ciphertext, rd_state, rd_key, rd_result;
`ifdef AES_CTRL_BLK_CNT_EN
    logic [31:0]  blk_count;
`endif
    int vectors = 0, errors = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_enc_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .rd_state(rd_state), .rd_key(rd_key), .rd_last(rd_last),
        .rd_result(rd_result), .busy(busy)
`ifdef AES_CTRL_BLK_CNT_EN
       ,.blk_count(blk_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // External round datapath: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] m [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) b[4*c+w] = a[4*((c+w)%4)+w];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
            m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? b[i] : m[i];
        return r ^ k;
    endfunction

    assign rd_result = aes_round(rd_state, rd_key, rd_last);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one pair for exactly one edge; callers check in_ready beforehand.
    task automatic accept(input logic [127:0] p, input logic [127:0] k);
        plaintext = p;
        key       = k;
        in_valid  = 1;
        tick();
        in_valid  = 0;
    endtask

    // Edges from the accepting edge until out_valid shows; -1 if it never does.
    task automatic run_to_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic take_out();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        vectors += 5;
        if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        if (ciphertext !== '0)    begin errors++; $display("FAIL reset ciphertext got %h want 0", ciphertext); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        if (rd_last !== 1'b0)     begin errors++; $display("FAIL reset rd_last got %b want 0", rd_last); end
    endtask

    // out_valid appears in the 11th cycle counting the accept cycle: 10 edges after the accepting edge.
    task automatic test_fips_b();
        int n;
        vectors += 6;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_b ready got %b want 1", in_ready); end
        accept(PT_B, KEY_B);
        if (busy !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL fips_b inflight busy=%b in_ready=%b want 1/0", busy, in_ready); end
        run_to_out(n);
        if (n != 10) begin errors++; $display("FAIL fips_b latency got %0d edges want 10", n); end
        if (ciphertext !== CT_B) begin errors++; $display("FAIL fips_b ct got %h want %h", ciphertext, CT_B); end
        take_out();
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL fips_b release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL fips_b idle busy got %b want 0", busy); end
    endtask

    // Inputs are scrambled and in_valid held after acceptance; result must be unaffected.
    task automatic test_fips_c();
        int n;
        accept(PT_C, KEY_C);
        plaintext = '1;
        key       = 128'hdeadbeef;
        in_valid  = 1;
        run_to_out(n);
        in_valid  = 0;
        vectors += 2;
        if (n != 10) begin errors++; $display("FAIL fips_c latency got %0d edges want 10", n); end
        if (ciphertext !== CT_C) begin errors++; $display("FAIL fips_c ct got %h want %h", ciphertext, CT_C); end
        take_out();
    endtask

    task automatic test_backpressure();
        int n;
        accept(PT_B, KEY_B);
        run_to_out(n);
        in_valid  = 1;
        plaintext = PT_C;
        key       = KEY_C;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (ciphertext !== CT_B || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin errors++; $display("FAIL backpressure cyc %0d ct=%h ov=%b ir=%b want %h/1/0", i, ciphertext, out_valid, in_ready, CT_B); end
            tick();
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        in_valid  = 0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL backpressure release ov=%b ir=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int n, seen;
        accept(PT_C, KEY_C);
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        vectors += 3;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_mid ir=%b ov=%b want 1/0", in_ready, out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", busy); end
        seen = 0;
        repeat (15) begin
            tick();
            if (out_valid) seen++;
        end
        if (seen != 0) begin errors++; $display("FAIL reset_mid abandoned out_valid cycles got %0d want 0", seen); end
        // Reset wins over a simultaneous input handshake.
        rst       = 1;
        in_valid  = 1;
        plaintext = PT_C;
        key       = KEY_C;
        tick();
        rst       = 0;
        in_valid  = 0;
        vectors += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_prio busy got %b want 0", busy); end
        if (ciphertext !== '0) begin errors++; $display("FAIL reset_prio ct got %h want 0", ciphertext); end
        accept(PT_B, KEY_B);
        run_to_out(n);
        vectors++;
        if (ciphertext !== CT_B || n != 10)
            begin errors++; $display("FAIL reset_mid next ct=%h n=%0d want %h/10", ciphertext, n, CT_B); end
        take_out();
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int lasts = 0, outs = 0;
        out_ready = 1;
        in_valid  = 1;
        plaintext = PT_B;
        key       = KEY_B;
        for (int c = 0; c < 36; c++) begin
            if (in_valid && in_ready) acc.push_back(c);
            if (rd_last) lasts++;
            if (out_valid) begin
                outs++;
                vectors++;
                if (ciphertext !== CT_B) begin errors++; $display("FAIL stream ct cyc %0d got %h want %h", c, ciphertext, CT_B); end
            end
            tick();
        end
        in_valid  = 0;
        out_ready = 0;
        vectors += 3;
        if (acc.size() != 3) begin errors++; $display("FAIL stream accepts got %0d want 3", acc.size()); end
        else for (int i = 1; i < 3; i++) begin
            vectors++;
            if (acc[i] - acc[i-1] != 12) begin errors++; $display("FAIL stream interval got %0d want 12", acc[i] - acc[i-1]); end
        end
        if (lasts != 3) begin errors++; $display("FAIL stream rd_last cycles got %0d want 3", lasts); end
        if (outs != 3) begin errors++; $display("FAIL stream out cycles got %0d want 3", outs); end
    endtask

`ifdef AES_CTRL_BLK_CNT_EN
    task automatic test_blk_count();
        int n;
        rst = 1;
        tick();
        rst = 0;
        repeat (3) begin
            accept(PT_C, KEY_C);
            run_to_out(n);
            take_out();
        end
        vectors++;
        if (blk_count !== 32'd3) begin errors++; $display("FAIL blk_count got %0d want 3", blk_count); end
        force dut.blk_count_q = 32'hffffffff;
        #1;
        release dut.blk_count_q;
        accept(PT_C, KEY_C);
        run_to_out(n);
        take_out();
        vectors++;
        if (blk_count !== 32'd0) begin errors++; $display("FAIL blk_count wrap got %h want 0", blk_count); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fips_b();
        test_fips_c();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_CTRL_BLK_CNT_EN
        test_blk_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
